// File: rtl/sample_decompressor.sv
// Re-expands the run-length compressed sample stream into one indexed sample per transfer.
// An accepted word appears on the output one cycle later. in_ready stays low while a run is being expanded.
module sample_decompressor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [15:0] in_data,
  input  logic        in_new_page,
  input  logic [39:0] in_index,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic [39:0] out_index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        format_error
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_SINGLE = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_REPEAT = 2'd3;

  logic [1:0]  state;
  logic [15:0] last;
  logic [15:0] rem;
  logic        cont;
  logic        synced;
  logic [39:0] exp_idx;
  logic        free;
  logic        accept;

  assign free     = !out_valid || out_ready;
  assign in_ready = free && (state != ST_REPEAT);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      last         <= 16'd0;
      rem          <= 16'd0;
      cont         <= 1'b0;
      synced       <= 1'b0;
      exp_idx      <= 40'd0;
      out_valid    <= 1'b0;
      out_data     <= 16'd0;
      out_index    <= 40'd0;
      format_error <= 1'b0;
    end else if (clear) begin
      state        <= ST_INIT;
      last         <= 16'd0;
      rem          <= 16'd0;
      cont         <= 1'b0;
      synced       <= 1'b0;
      exp_idx      <= 40'd0;
      out_valid    <= 1'b0;
      out_data     <= 16'd0;
      out_index    <= 40'd0;
      format_error <= 1'b0;
    end else if (free) begin
      out_valid <= 1'b0;
      if (state == ST_REPEAT) begin
        out_valid <= 1'b1;
        out_data  <= last;
        out_index <= exp_idx;
        exp_idx   <= exp_idx + 40'd1;
        rem       <= rem - 16'd1;
        // A saturated count (0xFFFF) chains into another count word.
        if (rem == 16'd1) state <= cont ? ST_COUNT : ST_INIT;
      end else if (accept) begin
        if (in_new_page) begin
          out_valid <= 1'b1;
          out_data  <= in_data;
          out_index <= in_index;
          exp_idx   <= in_index + 40'd1;
          last      <= in_data;
          state     <= ST_SINGLE;
          synced    <= 1'b1;
          if (synced && (in_index != exp_idx)) format_error <= 1'b1;
        end else begin
          if (!synced) format_error <= 1'b1;
          if (state == ST_COUNT) begin
            if (in_data == 16'd0) begin
              state <= ST_INIT;
            end else begin
              rem   <= in_data;
              cont  <= &in_data;
              state <= ST_REPEAT;
            end
          end else begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_index <= exp_idx;
            exp_idx   <= exp_idx + 40'd1;
            last      <= in_data;
            state     <= ((state == ST_SINGLE) && (in_data == last)) ? ST_COUNT : ST_SINGLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_decompressor.sv
// Randomized and directed checks of sample_decompressor against a stream-level expansion model.
module tb_sample_decompressor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_new_page = 1'b0;
  logic [39:0] in_index = 40'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic [39:0] out_index;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        format_error;

  sample_decompressor dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_data(in_data), .in_new_page(in_new_page), .in_index(in_index),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .format_error(format_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [15:0] w_dat[$];
  bit          w_np[$];
  logic [39:0] w_idx[$];
  logic [15:0] e_dat[$];
  logic [39:0] e_idx[$];
  bit          exp_err;
  logic [39:0] m_next;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic add_word(input logic [15:0] d, input bit np, input logic [39:0] idx);
    w_dat.push_back(d);
    w_np.push_back(np);
    w_idx.push_back(idx);
  endtask

  task automatic emit(input logic [15:0] d, inout logic [39:0] ex);
    e_dat.push_back(d);
    e_idx.push_back(ex);
    ex = ex + 40'd1;
  endtask

  // Parses the word list as pages of raw samples where an equal pair introduces count words.
  task automatic build_model();
    int i;
    bit synced;
    bit have_prev;
    logic [15:0] prev;
    logic [15:0] w;
    logic [15:0] c;
    logic [39:0] ex;
    i = 0; synced = 0; have_prev = 0; prev = 16'd0; ex = 40'd0;
    e_dat.delete(); e_idx.delete(); exp_err = 0;
    while (i < w_dat.size()) begin
      w = w_dat[i];
      if (w_np[i]) begin
        if (synced && (w_idx[i] != ex)) exp_err = 1;
        synced = 1;
        ex = w_idx[i];
        emit(w, ex);
        prev = w; have_prev = 1;
        i++;
      end else begin
        if (!synced) exp_err = 1;
        emit(w, ex);
        i++;
        if (have_prev && (w == prev)) begin
          have_prev = 0;
          while (i < w_dat.size() && !w_np[i]) begin
            c = w_dat[i];
            i++;
            for (int k = 0; k < int'(c); k++) emit(w, ex);
            if (c != 16'hFFFF) break;
          end
        end else begin
          prev = w; have_prev = 1;
        end
      end
    end
    m_next = ex;
  endtask

  task automatic run(input int mode, input int stop_after, input bit vgaps);
    int wi;
    int oi;
    int cyc;
    int limit;
    int extra;
    wi = 0; oi = 0; cyc = 0; extra = 0;
    limit = e_dat.size() * 4 + w_dat.size() * 8 + 100;
    while ((oi < e_dat.size() || wi < w_dat.size()) && (stop_after == 0 || oi < stop_after) && cyc < limit) begin
      @(negedge clk);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      if (wi < w_dat.size() && (!vgaps || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data = w_dat[wi];
        in_new_page = w_np[wi];
        in_index = w_idx[wi];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (oi < e_dat.size()) begin
          chk("out_data", 40'(out_data), 40'(e_dat[oi]));
          chk("out_index", out_index, e_idx[oi]);
        end else begin
          chk("surplus_out", 40'd1, 40'd0);
        end
        oi++;
      end
      if (in_valid && in_ready) wi++;
      cyc++;
    end
    if (cyc >= limit) chk("timeout", 40'(cyc), 40'(limit));
    if (stop_after == 0) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        if (out_valid) extra++;
      end
      chk("extra_outputs", 40'(extra), 40'd0);
      chk("sample_count", 40'(oi), 40'(e_dat.size()));
      chk("format_error", 40'(format_error), 40'(exp_err));
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    w_dat.delete(); w_np.delete(); w_idx.delete();
  endtask

  task automatic gen_random();
    logic [15:0] lastv;
    logic [15:0] v;
    logic [39:0] pidx;
    int pages;
    int toks;
    pages = $urandom_range(2, 4);
    for (int p = 0; p < pages; p++) begin
      if (p == 0) begin
        pidx = ($urandom_range(0, 1) == 1) ? 40'hFF_FFFF_FFFD : 40'($urandom_range(0, 5000));
      end else begin
        build_model();
        pidx = ($urandom_range(0, 2) != 0) ? m_next : 40'($urandom_range(0, 5000));
      end
      lastv = 16'h0011 * 16'($urandom_range(1, 4));
      add_word(lastv, 1'b1, pidx);
      toks = $urandom_range(1, 5);
      for (int t = 0; t < toks; t++) begin
        do v = 16'h0011 * 16'($urandom_range(1, 4)); while (v == lastv);
        if ($urandom_range(0, 1) == 1) begin
          add_word(v, 1'b0, 40'd0);
          lastv = v;
        end else begin
          add_word(v, 1'b0, 40'd0);
          add_word(v, 1'b0, 40'd0);
          if (!(t == toks - 1 && p < pages - 1 && $urandom_range(0, 2) == 0))
            add_word(16'($urandom_range(0, 7)), 1'b0, 40'd0);
          lastv = 16'd0;
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 40'(out_valid), 40'd0);
    chk("rst_out_data", 40'(out_data), 40'd0);
    chk("rst_out_index", out_index, 40'd0);
    chk("rst_format_error", 40'(format_error), 40'd0);
    chk("rst_in_ready", 40'(in_ready), 40'd1);

    // Basic run: 1234, 5555 x5, 00FF at 0..6
    add_word(16'h1234, 1'b1, 40'd0);
    add_word(16'h5555, 1'b0, 40'd0);
    add_word(16'h5555, 1'b0, 40'd0);
    add_word(16'd3, 1'b0, 40'd0);
    add_word(16'h00FF, 1'b0, 40'd0);
    build_model();
    run(0, 0, 0);

    // Zero count returns to INIT; Y then decodes as a fresh raw sample
    do_clear();
    add_word(16'h4242, 1'b1, 40'd100);
    add_word(16'h4242, 1'b0, 40'd0);
    add_word(16'd0, 1'b0, 40'd0);
    add_word(16'h0777, 1'b0, 40'd0);
    add_word(16'h0777, 1'b0, 40'd0);
    add_word(16'd1, 1'b0, 40'd0);
    build_model();
    run(1, 0, 1);

    // Saturated count chaining into a second count
    do_clear();
    add_word(16'hBEEF, 1'b1, 40'd0);
    add_word(16'hBEEF, 1'b0, 40'd0);
    add_word(16'hFFFF, 1'b0, 40'd0);
    add_word(16'd2, 1'b0, 40'd0);
    add_word(16'h0C0C, 1'b0, 40'd0);
    build_model();
    chk("long_model_len", 40'(e_dat.size()), 40'd65540);
    run(0, 0, 0);

    // Stalled output pattern 1,0,0,1
    do_clear();
    add_word(16'h0A0A, 1'b1, 40'd7);
    add_word(16'h0A0A, 1'b0, 40'd0);
    add_word(16'd6, 1'b0, 40'd0);
    add_word(16'h0B0B, 1'b0, 40'd0);
    build_model();
    run(2, 0, 0);

    // Unsynced start, then a page with the wrong index
    do_clear();
    add_word(16'h0001, 1'b0, 40'd0);
    add_word(16'h0002, 1'b0, 40'd0);
    add_word(16'h0003, 1'b0, 40'd0);
    add_word(16'h0004, 1'b0, 40'd0);
    add_word(16'h0005, 1'b0, 40'd0);
    add_word(16'h0009, 1'b1, 40'd10);
    build_model();
    run(1, 0, 0);

    // Clear in the middle of a run
    do_clear();
    add_word(16'h0007, 1'b0, 40'd0);
    add_word(16'h0ABC, 1'b1, 40'd0);
    add_word(16'h0ABC, 1'b0, 40'd0);
    add_word(16'd100, 1'b0, 40'd0);
    build_model();
    run(0, 62, 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("pre_clear_error", 40'(format_error), 40'd1);
    chk("pre_clear_in_ready", 40'(in_ready), 40'd0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clear_out_valid", 40'(out_valid), 40'd0);
    chk("clear_in_ready", 40'(in_ready), 40'd1);
    chk("clear_format_error", 40'(format_error), 40'd0);
    @(negedge clk);
    clear = 1'b0;
    w_dat.delete(); w_np.delete(); w_idx.delete();
    add_word(16'hABCD, 1'b1, 40'd500);
    add_word(16'hABCD, 1'b0, 40'd0);
    add_word(16'd2, 1'b0, 40'd0);
    add_word(16'h1111, 1'b0, 40'd0);
    build_model();
    run(1, 0, 1);

    for (int r = 0; r < 6; r++) begin
      do_clear();
      gen_random();
      build_model();
      run(1, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
